// File: rtl/fp_div_seq.sv
// fp_div_seq: iterative IEEE-754 binary32 divider, fp_Z = fp_X / fp_Y.
// A restoring divider retires one quotient bit per cycle over 26 cycles, and a
// ROUND cycle then normalizes, rounds and packs the result.
// Optional feature macro: FP_DIV_FAST_SPECIAL_EN. When it is defined, special
// operands skip DIV/ROUND and the result is ready one cycle after accept.
// When it is undefined, every operand has the same 28-cycle latency.
module fp_div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] fp_X,
  input  logic [31:0] fp_Y,
  input  logic [2:0]  r_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] fp_Z,
  output logic        ovrf,
  output logic        udrf,
  output logic        zer,
  output logic        inf,
  output logic        nan,
  output logic        dz
);

  typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;

  state_t r_state, w_next;

  logic              r_sign;
  logic signed [9:0] r_exp;
  logic [24:0]       r_rem;
  logic [23:0]       r_div;
  logic [25:0]       r_quo;
  logic [4:0]        r_cnt;
  logic [2:0]        r_rnd;
  logic              r_special;
  logic [31:0]       r_spZ;
  logic [5:0]        r_spFlags;
  logic [31:0]       r_z;
  logic [5:0]        r_flags;   // {ovrf, udrf, zer, inf, nan, dz}

  logic w_accept;
  assign w_accept  = in_valid && (r_state == IDLE);
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);

  // Operand classification on the live inputs; subnormals count as zero.
  logic [7:0] w_xExp, w_yExp;
  logic       w_xZero, w_yZero, w_xInf, w_yInf, w_xNan, w_yNan;
  logic       w_isNan, w_isDz, w_isInf, w_isZero, w_special, w_sign;
  logic [31:0] w_spZ;
  logic [5:0]  w_spFlags;

  assign w_xExp  = fp_X[30:23];
  assign w_yExp  = fp_Y[30:23];
  assign w_xZero = (w_xExp == 8'd0);
  assign w_yZero = (w_yExp == 8'd0);
  assign w_xInf  = (w_xExp == 8'hFF) && (fp_X[22:0] == 23'd0);
  assign w_yInf  = (w_yExp == 8'hFF) && (fp_Y[22:0] == 23'd0);
  assign w_xNan  = (w_xExp == 8'hFF) && (fp_X[22:0] != 23'd0);
  assign w_yNan  = (w_yExp == 8'hFF) && (fp_Y[22:0] != 23'd0);
  assign w_sign  = fp_X[31] ^ fp_Y[31];

  assign w_isNan   = w_xNan || w_yNan || (w_xZero && w_yZero) || (w_xInf && w_yInf);
  assign w_isDz    = !w_isNan && !w_xZero && !w_xInf && w_yZero;
  assign w_isInf   = !w_isNan && (w_isDz || w_xInf);
  assign w_isZero  = !w_isNan && !w_isInf && (w_xZero || w_yInf);
  assign w_special = w_isNan || w_isInf || w_isZero;

  assign w_spZ = w_isNan ? 32'h7FC0_0000 :
                 w_isInf ? {w_sign, 8'hFF, 23'd0} : {w_sign, 31'd0};
  assign w_spFlags = {1'b0, 1'b0, w_isZero, w_isInf, w_isNan, w_isDz};

  // One restoring-division step: subtract the divisor when it fits, then shift.
  logic        w_ge;
  logic [24:0] w_diff, w_remSel;
  assign w_ge     = (r_rem >= {1'b0, r_div});
  assign w_diff   = r_rem - {1'b0, r_div};
  assign w_remSel = w_ge ? w_diff : r_rem;

  // Normalize, round and pack the finished quotient.
  logic [23:0]       w_mant;
  logic              w_g, w_s, w_inc;
  logic signed [9:0] w_eNorm, w_eFinal;
  logic [24:0]       w_mantR;
  logic [22:0]       w_frac;
  logic [31:0]       w_packZ;
  logic [5:0]        w_packFlags;

  always_comb begin
    w_mant      = r_quo[24:1];
    w_g         = r_quo[0];
    w_s         = (r_rem != 25'd0);
    w_eNorm     = r_exp - 10'sd1;
    w_inc       = 1'b0;
    w_packZ     = 32'd0;
    w_packFlags = 6'd0;
    if (r_quo[25]) begin
      w_mant  = r_quo[25:2];
      w_g     = r_quo[1];
      w_s     = (r_rem != 25'd0) || r_quo[0];
      w_eNorm = r_exp;
    end
    case (r_rnd)
      3'b001:  w_inc = 1'b0;
      3'b010:  w_inc = r_sign & (w_g | w_s);
      3'b011:  w_inc = !r_sign & (w_g | w_s);
      3'b100:  w_inc = w_g;
      default: w_inc = w_g & (w_s | w_mant[0]);
    endcase
    w_mantR = {1'b0, w_mant} + {24'd0, w_inc};
    // The hidden bit drops out of bit 23 only when rounding carried into
    // bit 24, and then the fraction is exactly zero.
    w_frac   = w_mantR[23] ? w_mantR[22:0] : 23'd0;
    w_eFinal = w_eNorm + {9'd0, w_mantR[24]};
    if (w_eFinal >= 10'sd255) begin
      w_packZ     = {r_sign, 8'hFF, 23'd0};
      w_packFlags = 6'b100100;
    end else if (w_eFinal <= 10'sd0) begin
      w_packZ     = {r_sign, 31'd0};
      w_packFlags = 6'b011000;
    end else begin
      w_packZ     = {r_sign, w_eFinal[7:0], w_frac};
      w_packFlags = 6'd0;
    end
  end

  // State register; reset wins over any accept on the same edge.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
`ifdef FP_DIV_FAST_SPECIAL_EN
          w_next = w_special ? DONE : DIV;
`else
          w_next = DIV;
`endif
        end
      end
      DIV:     if (r_cnt == 5'd25) w_next = ROUND;
      ROUND:   w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand capture, division iterations and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sign    <= 1'b0;
      r_exp     <= 10'sd0;
      r_rem     <= 25'd0;
      r_div     <= 24'd0;
      r_quo     <= 26'd0;
      r_cnt     <= 5'd0;
      r_rnd     <= 3'd0;
      r_special <= 1'b0;
      r_spZ     <= 32'd0;
      r_spFlags <= 6'd0;
      r_z       <= 32'd0;
      r_flags   <= 6'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_sign    <= w_sign;
            r_exp     <= {2'b00, w_xExp} - {2'b00, w_yExp} + 10'sd127;
            r_rem     <= {2'b01, fp_X[22:0]};
            r_div     <= {1'b1, fp_Y[22:0]};
            r_quo     <= 26'd0;
            r_cnt     <= 5'd0;
            r_rnd     <= r_mode;
            r_special <= w_special;
            r_spZ     <= w_spZ;
            r_spFlags <= w_spFlags;
`ifdef FP_DIV_FAST_SPECIAL_EN
            if (w_special) begin
              r_z     <= w_spZ;
              r_flags <= w_spFlags;
            end
`endif
          end
        end
        DIV: begin
          r_quo <= {r_quo[24:0], w_ge};
          r_rem <= w_remSel << 1;
          r_cnt <= r_cnt + 5'd1;
        end
        ROUND: begin
          r_z     <= r_special ? r_spZ : w_packZ;
          r_flags <= r_special ? r_spFlags : w_packFlags;
        end
        default: ;
      endcase
    end
  end

  assign fp_Z = r_z;
  assign ovrf = r_flags[5];
  assign udrf = r_flags[4];
  assign zer  = r_flags[3];
  assign inf  = r_flags[2];
  assign nan  = r_flags[1];
  assign dz   = r_flags[0];

endmodule

// File: tb/tb_fp_div_seq.sv
// Scoreboard bench for fp_div_seq: a driver pushes expected results on
// accept, and a monitor pops and compares whenever a new result is presented.
module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] fp_X, fp_Y;
  logic [2:0]  r_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] fp_Z;
  logic        ovrf, udrf, zer, inf, nan, dz;

  localparam logic [5:0] F_NONE = 6'b000000;
  localparam logic [5:0] F_OVRF = 6'b100000;
  localparam logic [5:0] F_UDRF = 6'b010000;
  localparam logic [5:0] F_ZER  = 6'b001000;
  localparam logic [5:0] F_INF  = 6'b000100;
  localparam logic [5:0] F_NAN  = 6'b000010;
  localparam logic [5:0] F_DZ   = 6'b000001;

  localparam int NORM_LAT = 28;
`ifdef FP_DIV_FAST_SPECIAL_EN
  localparam int SPEC_LAT = 1;
`else
  localparam int SPEC_LAT = 28;
`endif

  typedef struct {
    logic [31:0] z;
    logic [5:0]  flags;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   seen = 1'b0;

  fp_div_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .fp_X(fp_X), .fp_Y(fp_Y), .r_mode(r_mode), .out_valid(out_valid),
    .out_ready(out_ready), .fp_Z(fp_Z), .ovrf(ovrf), .udrf(udrf),
    .zer(zer), .inf(inf), .nan(nan), .dz(dz)
  );

  always #5 clk = ~clk;

  // Cycle counter used to measure accept-to-valid latency.
  always @(posedge clk) cyc++;

  function automatic logic [5:0] dutFlags();
    return {ovrf, udrf, zer, inf, nan, dz};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: bound expired", name);
  endtask

  task automatic checkOutput(input exp_t e);
    check({e.name, " fp_Z"}, fp_Z, e.z);
    check({e.name, " flags"}, {26'd0, dutFlags()}, {26'd0, e.flags});
    check({e.name, " latency"}, 32'(cyc - e.acc + 1), 32'(e.lat));
  endtask

  // Monitor: compare each newly presented result against the scoreboard.
  always @(negedge clk) begin
    if (!out_valid) begin
      seen = 1'b0;
    end else if (!seen) begin
      seen = 1'b1;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected result: got %h, expected none", fp_Z);
      end else begin
        checkOutput(sb.pop_front());
      end
    end
  end

  task automatic waitReady(input string name, output bit ok);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    if (!ok) failNow({name, " in_ready wait"});
  endtask

  task automatic applyStimulus(input string name, input logic [31:0] x, input logic [31:0] y,
                               input logic [2:0] m, input logic [31:0] ez,
                               input logic [5:0] ef, input int el);
    bit   ok;
    exp_t e;
    waitReady(name, ok);
    if (!ok) return;
    fp_X     = x;
    fp_Y     = y;
    r_mode   = m;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    fp_X     = 32'hDEAD_BEEF;
    fp_Y     = 32'h0000_0000;
    r_mode   = 3'b011;
    e.z = ez; e.flags = ef; e.lat = el; e.acc = cyc; e.name = name;
    sb.push_back(e);
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      failNow({name, " drain"});
      sb.delete();
    end
  endtask

  initial begin
    bit ok;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    fp_X      = 32'd0;
    fp_Y      = 32'd0;
    r_mode    = 3'd0;
    @(posedge clk);
    @(negedge clk);
    check("reset in_ready", {31'd0, in_ready}, 32'd1);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset fp_Z", fp_Z, 32'd0);
    check("reset flags", {26'd0, dutFlags()}, 32'd0);
    rst = 1'b0;

    // Normal path and rounding modes.
    applyStimulus("6/2 RNE",   32'h40C00000, 32'h40000000, 3'b000, 32'h40400000, F_NONE, NORM_LAT);
    applyStimulus("1/3 RNE",   32'h3F800000, 32'h40400000, 3'b000, 32'h3EAAAAAB, F_NONE, NORM_LAT);
    applyStimulus("1/3 RTZ",   32'h3F800000, 32'h40400000, 3'b001, 32'h3EAAAAAA, F_NONE, NORM_LAT);
    applyStimulus("1/3 RUP",   32'h3F800000, 32'h40400000, 3'b011, 32'h3EAAAAAB, F_NONE, NORM_LAT);
    applyStimulus("1/3 RDN",   32'h3F800000, 32'h40400000, 3'b010, 32'h3EAAAAAA, F_NONE, NORM_LAT);
    applyStimulus("1/3 RMM",   32'h3F800000, 32'h40400000, 3'b100, 32'h3EAAAAAB, F_NONE, NORM_LAT);
    applyStimulus("1/3 m111",  32'h3F800000, 32'h40400000, 3'b111, 32'h3EAAAAAB, F_NONE, NORM_LAT);
    applyStimulus("-1/3 RDN",  32'hBF800000, 32'h40400000, 3'b010, 32'hBEAAAAAB, F_NONE, NORM_LAT);
    applyStimulus("-1/3 RUP",  32'hBF800000, 32'h40400000, 3'b011, 32'hBEAAAAAA, F_NONE, NORM_LAT);
    applyStimulus("-6/2 RNE",  32'hC0C00000, 32'h40000000, 3'b000, 32'hC0400000, F_NONE, NORM_LAT);
    applyStimulus("maxm/1",    32'h3FFFFFFF, 32'h3F800000, 3'b000, 32'h3FFFFFFF, F_NONE, NORM_LAT);

    // Special operands.
    applyStimulus("1/0",       32'h3F800000, 32'h00000000, 3'b000, 32'h7F800000, F_INF | F_DZ, SPEC_LAT);
    applyStimulus("0/0",       32'h00000000, 32'h00000000, 3'b000, 32'h7FC00000, F_NAN, SPEC_LAT);
    applyStimulus("-inf/2",    32'hFF800000, 32'h40000000, 3'b000, 32'hFF800000, F_INF, SPEC_LAT);
    applyStimulus("nan/1",     32'hFFC00001, 32'h3F800000, 3'b000, 32'h7FC00000, F_NAN, SPEC_LAT);
    applyStimulus("-2/inf",    32'hC0000000, 32'h7F800000, 3'b000, 32'h80000000, F_ZER, SPEC_LAT);
    applyStimulus("sub/1",     32'h00400000, 32'h3F800000, 3'b000, 32'h00000000, F_ZER, SPEC_LAT);

    // Range limits.
    applyStimulus("ovf",       32'h7F000000, 32'h3E800000, 3'b000, 32'h7F800000, F_OVRF | F_INF, NORM_LAT);
    applyStimulus("udf",       32'h00800000, 32'h40000000, 3'b000, 32'h00000000, F_UDRF | F_ZER, NORM_LAT);
    waitDrain("range");

    // Backpressure: result must hold while the consumer stalls.
    out_ready = 1'b0;
    applyStimulus("bp 6/2", 32'h40C00000, 32'h40000000, 3'b000, 32'h40400000, F_NONE, NORM_LAT);
    begin
      int n = 0;
      while (!out_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (!out_valid) failNow("bp out_valid wait");
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp hold fp_Z", fp_Z, 32'h40400000);
      check("bp hold flags", {26'd0, dutFlags()}, 32'd0);
      check("bp hold in_ready", {31'd0, in_ready}, 32'd0);
      check("bp hold out_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp release in_ready", {31'd0, in_ready}, 32'd1);
    applyStimulus("bp next 1/3", 32'h3F800000, 32'h40400000, 3'b001, 32'h3EAAAAAA, F_NONE, NORM_LAT);
    waitDrain("bp");

    // Reset in the middle of DIV discards the in-flight operation.
    waitReady("abort", ok);
    if (ok) begin
      fp_X     = 32'h40C00000;
      fp_Y     = 32'h40000000;
      r_mode   = 3'b000;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort out_valid", {31'd0, out_valid}, 32'd0);
      check("abort in_ready", {31'd0, in_ready}, 32'd1);
      check("abort fp_Z", fp_Z, 32'd0);
      repeat (35) @(negedge clk);
    end
    applyStimulus("post-rst 6/2", 32'h40C00000, 32'h40000000, 3'b000, 32'h40400000, F_NONE, NORM_LAT);
    waitDrain("final");
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_div_seq.md
# fp_div_seq

Iterative IEEE-754 single-precision divider, fp_Z = fp_X / fp_Y, for the ALU alongside the combinational multiplier. It uses the same rounding-mode encoding, exception flags and flush-to-zero policy as the multiplier. A restoring divider produces one quotient bit per cycle. Operands enter and results leave through valid/ready handshakes, so the block sits behind the ALU issue stage and in front of writeback.

## Interface
- None: no parameters; format fixed at binary32.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  operands valid.
- in_ready  out  1  block accepts operands; high only in IDLE.
- fp_X  in  32  dividend.
- fp_Y  in  32  divisor.
- r_mode  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101–111 treated as RNE.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- fp_Z  out  32  quotient.
- ovrf  out  1  exponent overflow.
- udrf  out  1  exponent underflow, result flushed.
- zer  out  1  fp_Z is ±0.
- inf  out  1  fp_Z is ±inf.
- nan  out  1  fp_Z is canonical NaN.
- dz  out  1  finite nonzero divided by zero.

## Operation
- States: IDLE, DIV, ROUND, DONE.
- Accept happens when in_valid && in_ready. fp_X, fp_Y and r_mode are registered on accept; later input changes are ignored.
- Subnormal inputs (exponent 0) are treated as ±0.
- Sign of the result is fp_X[31] ^ fp_Y[31]. NaN results always have sign bit 0.
- Special cases are classified in the accept cycle:
  - NaN operand, 0/0, or inf/inf: fp_Z=0x7FC00000, nan=1.
  - Finite nonzero / 0: ±inf, inf=1, dz=1.
  - inf / finite: ±inf, inf=1.
  - 0 / nonzero, or finite / inf: ±0, zer=1.
- Normal path:
  - Mantissas are mX={1,fX} and mY={1,fY}.
  - Exponent is a 10-bit signed value, e = eX − eY + 127.
  - DIV runs 26 iterations of restoring division, producing q[25:0] with q[25] weighted 2^0.
  - Sticky s = (remainder ≠ 0).
- Normalization:
  - If q[25]=1: mantissa = q[25:2], guard g = q[1], s |= q[0].
  - Otherwise: mantissa = q[24:1], g = q[0], and e is decremented by 1.
- Rounding increment by mode:
  - RNE: g & (s | lsb).
  - RTZ: 0.
  - RDN: sign & (g|s).
  - RUP: !sign & (g|s).
  - RMM: g.
- If the mantissa carries out on rounding: mantissa becomes 1.0 and e is incremented by 1.
- Post-rounding checks:
  - e ≥ 255: ±inf, ovrf=1, inf=1 (all modes).
  - e ≤ 0: ±0, udrf=1, zer=1.
- Flags are mutually consistent: at most one of nan, inf, or zer is set; dz implies inf.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, fp_Z=0, and all flags 0.
- Accept at edge N:
  - Normal operands: state is DIV after edge N. Iterations run on edges N+1…N+26. ROUND packs on edge N+27. out_valid=1 after edge N+27, a latency of 28 cycles.
  - Special operands: with the fast-special feature compiled in, state goes to DONE at edge N and out_valid=1 after edge N.
- DONE holds fp_Z and the flags stable while out_valid && !out_ready.
- Handshake on edge M (out_valid && out_ready): state goes to IDLE and in_ready=1 after edge M. No accept occurs at edge M itself; minimum issue interval is latency+1.
- While not in IDLE, in_ready=0 and in_valid is ignored.
- rst asserted in any state: after that edge, state=IDLE, out_valid=0, outputs cleared, and any in-flight operation is discarded. rst takes priority over an accept on the same edge.

## Configuration
- FP_DIV_FAST_SPECIAL_EN defined: special cases bypass DIV/ROUND and go to DONE at the accept edge (latency 1).
- FP_DIV_FAST_SPECIAL_EN undefined: special cases traverse DIV (26 cycles) and ROUND with the datapath result discarded. Latency is a constant 28 cycles for all operands, and fp_Z and the flags are identical to the defined case.

## Test plan
- 0x40C00000 / 0x40000000, RNE → fp_Z=0x40400000 with all flags 0, out_valid 28 cycles after accept.
- 0x3F800000 / 0x40400000 → RNE gives 0x3EAAAAAB; RTZ gives 0x3EAAAAAA; RUP gives 0x3EAAAAAB; RDN gives 0x3EAAAAAA.
- Specials:
  - 0x3F800000 / 0x00000000 → 0x7F800000 with inf=1 and dz=1.
  - 0x00000000 / 0x00000000 → 0x7FC00000 with nan=1.
  - 0xFF800000 / 0x40000000 → 0xFF800000 with inf=1.
  - Each checked at latency 1 and at latency 28, once per macro setting.
- Range limits:
  - 0x7F000000 / 0x3E800000 → 0x7F800000 with ovrf=1 and inf=1.
  - 0x00800000 / 0x40000000 → 0x00000000 with udrf=1 and zer=1.
  - 0x00400000 (subnormal) / 0x3F800000 → 0x00000000 with zer=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → fp_Z and flags stable, in_ready=0. Then out_ready=1 → in_ready=1 on the next cycle, and a new operand is accepted.
- Assert rst at DIV iteration 10 → out_valid=0, in_ready=1 next cycle. A fresh 0x40C00000/0x40000000 issued afterwards returns 0x40400000.
